// File: rtl/alarm_bank_pkg.sv
// Shared definitions for the alarm bank.
// Mode encodings and the select-width helper.
package alarm_bank_pkg;

  typedef enum logic {
    ALARM_ONESHOT  = 1'b0,
    ALARM_PERIODIC = 1'b1
  } alarm_mode_e;

  localparam int ALARM_MAX_N = 16;

  function automatic int alarm_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_bank_channel.sv
// One alarm channel: countdown, one-shot or periodic reload,
// sticky bell and overrun flags.
module alarm_bank_channel
  import alarm_bank_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] value,
  input  logic         mode,
  input  logic         ack,
  output logic         bell,
  output logic         overrun,
  output logic         active
);

  logic [W-1:0] count;
  logic [W-1:0] period;
  alarm_mode_e  mode_q;
  logic         expire;

  // load/kill on this channel pre-empt the expiry
  assign expire = tick && (count == W'(1)) && !load && !kill;
  assign active = (count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      period <= '0;
      mode_q <= ALARM_ONESHOT;
    end else if (load) begin
      count  <= value;
      period <= value;
      mode_q <= alarm_mode_e'(mode);
    end else if (kill) begin
      count <= '0;
    end else if (expire) begin
      count <= (mode_q == ALARM_PERIODIC) ? period : '0;
    end else if (tick && (count > W'(1))) begin
      count <= count - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bell    <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      bell    <= 1'b0;
      overrun <= 1'b0;
    end else if (expire) begin
      bell    <= 1'b1;
      overrun <= ack ? 1'b0 : (overrun | bell);
    end else if (ack) begin
      bell    <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// N-channel alarm bank with shared put/stop port and masked irq.
// Optional shared prescaler enabled by ALARM_BANK_PRESCALE_EN.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = alarm_sel_w(N)
`ifdef ALARM_BANK_PRESCALE_EN
  ,
  parameter int PW = 8
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] sel,
  input  logic [W-1:0]  value,
  input  logic          mode,
  input  logic          put,
  input  logic          stop,
  input  logic [N-1:0]  ack,
  input  logic [N-1:0]  mask,
`ifdef ALARM_BANK_PRESCALE_EN
  input  logic [PW-1:0] div,
`endif
  output logic [N-1:0]  bell,
  output logic [N-1:0]  overrun,
  output logic [N-1:0]  active,
  output logic          irq
);

  logic         tick;
  logic         sel_ok;
  logic [N-1:0] load;
  logic [N-1:0] kill;

`ifdef ALARM_BANK_PRESCALE_EN
  logic [PW-1:0] pre;

  assign tick = (pre == div);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign sel_ok = (int'(sel) < N);

  for (genvar g = 0; g < N; g++) begin : g_ch
    // put wins over stop on the same channel
    assign load[g] = put && sel_ok && (sel == CW'(g));
    assign kill[g] = stop && !put && sel_ok && (sel == CW'(g));

    alarm_bank_channel #(
      .W(W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .tick    (tick),
      .load    (load[g]),
      .kill    (kill[g]),
      .value   (value),
      .mode    (mode),
      .ack     (ack[g]),
      .bell    (bell[g]),
      .overrun (overrun[g]),
      .active  (active[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(bell & mask);
    end
  end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- N-channel successor to the single alarm timer; each channel has its own W-bit countdown, one-shot or periodic mode, a sticky bell and an overrun flag.
- Software or a sequencer programs one channel per cycle through a shared select/value/put port.
- Bells are masked into one level interrupt for the system interrupt controller.
- Sits beside the existing timer blocks; a one-channel, one-shot configuration reproduces the single alarm's timing.

Parameters:
- W, 8, countdown width in bits (W >= 2).
- N, 4, number of channels (1..16).
- CW, 2, select width; must satisfy 2**CW >= N.

Ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; low forces all state to reset values immediately; release is synchronised externally.
- sel  input  CW  channel addressed by put/stop.
- value  input  W  load value; period in periodic mode.
- mode  input  1  0 = one-shot, 1 = periodic; sampled with put.
- put  input  1  load/arm the selected channel.
- stop  input  1  disarm the selected channel.
- ack  input  N  per-channel bell/overrun clear, one bit per channel.
- mask  input  N  per-channel interrupt enable.
- bell  output  N  registered, sticky expiry flags.
- overrun  output  N  registered, sticky missed-acknowledge flags.
- active  output  N  registered, channel armed (count != 0).
- irq  output  1  registered OR of (bell & mask).

Behaviour:
- Reset (reset low): all counts 0, all modes 0, all periods 0; bell, overrun, active and irq all 0.
- Put on edge t with value V > 0:
  - count <= V, period <= V, mode latched, active <= 1.
  - The channel's bell and overrun are cleared.
- Put with V = 0: count 0, active 0, bell and overrun cleared, so the channel is disarmed.
- Tick: each edge while count > 1 decrements count; there is no wrap-around below 0.
- Expiry is the edge where count == 1 and no put/stop targets the channel. At expiry:
  - bell <= 1.
  - One-shot: count <= 0 and active <= 0.
  - Periodic: count <= period and active stays 1.
- Latency: with one-shot V = 3 put at edge 0, bell reads 1 after edge 3. Periodic expiries occur every V edges.
- Overrun: expiry while bell is already 1 and not being acked that cycle sets overrun <= 1.
- Stop on the selected channel: count 0 and active 0; bell and overrun are unchanged.
- If sel >= N, put and stop are ignored.
- Simultaneous events, in priority order:
  - reset
  - put/stop on the channel beats its expiry; if both put and stop are asserted, put wins.
  - expiry set beats ack clear: the bell stays 1 and overrun is not set.
- ack[i] alone clears bell[i] and overrun[i] on the next edge.
- Other channels are never affected by put/stop/ack aimed elsewhere.
- irq is registered, so it follows bell & mask by one cycle.
- A mask change affects irq only, never bell.

Optional Feature:
- Macro: ALARM_BANK_PRESCALE_EN.
- When defined:
  - Adds parameter PW (default 8) and input div [PW-1:0].
  - A shared free-running prescaler counts 0..div and emits a one-cycle tick at wrap.
  - Counts decrement and expire only on tick edges. div = 0 means a tick every clock.
  - Put/stop/ack act immediately, independent of tick.
  - The prescaler resets to 0 on reset only.
- When undefined: there is no div port, tick is permanently 1, and timing is exactly as above.

Decomposition:
- Shared package/include holds:
  - mode encodings (ALARM_ONESHOT = 0, ALARM_PERIODIC = 1)
  - the select-width helper constant
- Natural sub-module: alarm_bank_channel, one channel with ports clock, reset, tick, load, kill, value, mode, ack, bell, overrun, active.
  - It is instantiated N times in a generate loop.
  - The top decodes sel into per-channel load/kill and forms irq.

Test Plan:
- Reset mid-countdown: arm ch0 V=5, pull reset low after 2 edges -> bell, active and irq are 0 at once; after release, no bell within 10 edges.
- One-shot: put ch1 V=3 mode=0 at edge 0 -> bell[1]=1 after edge 3, active[1]=0; irq=1 after edge 4 with mask[1]=1.
- Periodic and overrun: put ch2 V=4 mode=1, never ack -> bell after edge 4, overrun after edge 8, active stays 1; ack[2] clears both next edge.
- Collisions:
  - ch3 V=2: assert ack[3] on the expiry edge -> bell[3] is 1 and overrun[3] is 0.
  - Put ch3 V=6 on its expiry edge -> no bell, new expiry 6 edges later.
- Isolation and range: sel=N (for N < 2**CW) with put -> no state change in any channel. Stop ch0 mid-count -> active[0]=0, other channels still expire on schedule.
- Prescale (macro defined): div=3, put V=2 -> bell after 8 clocks ±3 depending on prescaler phase; with div=0 the timing matches the undefined build.
